// File: rtl/chess_timer_pkg.sv
// Shared types and constants for the chess game clock.
package chess_timer_pkg;

    // BCD mm:ss word width
    localparam int MMSS_W = 16;

    localparam logic [MMSS_W-1:0] BCD_ZERO = 16'h0000;

    localparam logic SIDE_RED   = 1'b0;
    localparam logic SIDE_BLACK = 1'b1;

    // ST_PAUSE is only reachable when the pause feature is built in
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_OVER  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/chess_timer_if.sv
// Control-event and display-word bundle between game control, the
// chess timer and the display engine. CHESS_TIMER_PAUSE_EN adds pause.
interface chess_timer_if;
    import chess_timer_pkg::*;

    logic              start;
    logic              move_done;
    logic              game_over;
`ifdef CHESS_TIMER_PAUSE_EN
    logic              pause;
`endif
    logic [MMSS_W-1:0] rr_timer;
    logic [MMSS_W-1:0] rt_timer;
    logic [MMSS_W-1:0] br_timer;
    logic [MMSS_W-1:0] bt_timer;
    logic              turn;
    logic [1:0]        timeout;
    logic              running;

`ifdef CHESS_TIMER_PAUSE_EN
    modport master (
        output start, move_done, game_over, pause,
        input  rr_timer, rt_timer, br_timer, bt_timer, turn, timeout, running
    );
    modport slave (
        input  start, move_done, game_over, pause,
        output rr_timer, rt_timer, br_timer, bt_timer, turn, timeout, running
    );
`else
    modport master (
        output start, move_done, game_over,
        input  rr_timer, rt_timer, br_timer, bt_timer, turn, timeout, running
    );
    modport slave (
        input  start, move_done, game_over,
        output rr_timer, rt_timer, br_timer, bt_timer, turn, timeout, running
    );
`endif

endinterface

// File: rtl/bcd_mmss_dec.sv
// One-second decrement of a BCD mm:ss word with digit borrows.
// 00:00 saturates; is_zero flags a zero result.
module bcd_mmss_dec
    import chess_timer_pkg::*;
(
    input  logic [MMSS_W-1:0] value,
    output logic [MMSS_W-1:0] dec,
    output logic              is_zero
);

    logic [3:0] m10, m1, s10, s1;

    // Borrow chain: seconds ones -> seconds tens (base 6) -> minutes
    always_comb begin
        m10 = value[15:12];
        m1  = value[11:8];
        s10 = value[7:4];
        s1  = value[3:0];
        if (value != BCD_ZERO) begin
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd9;
                if (s10 != 4'd0) begin
                    s10 = s10 - 4'd1;
                end else begin
                    s10 = 4'd5;
                    if (m1 != 4'd0) begin
                        m1 = m1 - 4'd1;
                    end else begin
                        m1  = 4'd9;
                        m10 = m10 - 4'd1;
                    end
                end
            end
        end
        dec     = {m10, m1, s10, s1};
        is_zero = ({m10, m1, s10, s1} == BCD_ZERO);
    end

endmodule

// File: rtl/chess_timer.sv
// Per-side chess game clock: round and total BCD mm:ss timers per side,
// counting down only for the side to move.
// Optional feature macro: CHESS_TIMER_PAUSE_EN (pause/resume state).
module chess_timer
    import chess_timer_pkg::*;
#(
    parameter int                CLK_HZ      = 25_000_000,
    parameter logic [MMSS_W-1:0] ROUND_LIMIT = 16'h0100,
    parameter logic [MMSS_W-1:0] TOTAL_LIMIT = 16'h1000
) (
    input  logic          vga_clk,
    input  logic          rst_n,
    chess_timer_if.slave  bus
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    state_t            state, state_n;
    logic [PW-1:0]     presc, presc_n;
    logic [MMSS_W-1:0] rr, rt, br, bt;
    logic [MMSS_W-1:0] rr_n, rt_n, br_n, bt_n;
    logic              turn, turn_n;
    logic [1:0]        timeout, timeout_n;
    logic              pause_req;

    logic [MMSS_W-1:0] round_dec, total_dec;
    logic              round_zero, total_zero;

`ifdef CHESS_TIMER_PAUSE_EN
    assign pause_req = bus.pause;
`else
    assign pause_req = 1'b0;
`endif

    // Only the side to move is ever decremented
    bcd_mmss_dec u_round_dec (
        .value   (turn ? br : rr),
        .dec     (round_dec),
        .is_zero (round_zero)
    );

    bcd_mmss_dec u_total_dec (
        .value   (turn ? bt : rt),
        .dec     (total_dec),
        .is_zero (total_zero)
    );

    // State and datapath registers
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            presc   <= '0;
            rr      <= ROUND_LIMIT;
            rt      <= TOTAL_LIMIT;
            br      <= ROUND_LIMIT;
            bt      <= TOTAL_LIMIT;
            turn    <= SIDE_RED;
            timeout <= 2'b00;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            rr      <= rr_n;
            rt      <= rt_n;
            br      <= br_n;
            bt      <= bt_n;
            turn    <= turn_n;
            timeout <= timeout_n;
        end
    end

    // Next state: game_over > move_done > pause > tick; move_done swallows a tick
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        rr_n      = rr;
        rt_n      = rt;
        br_n      = br;
        bt_n      = bt;
        turn_n    = turn;
        timeout_n = timeout;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    rr_n      = ROUND_LIMIT;
                    br_n      = ROUND_LIMIT;
                    rt_n      = TOTAL_LIMIT;
                    bt_n      = TOTAL_LIMIT;
                    timeout_n = 2'b00;
                    turn_n    = SIDE_RED;
                    presc_n   = '0;
                    state_n   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.game_over) begin
                    state_n = ST_OVER;
                end else if (bus.move_done) begin
                    turn_n  = ~turn;
                    rr_n    = ROUND_LIMIT;
                    br_n    = ROUND_LIMIT;
                    presc_n = '0;
                end else if (pause_req) begin
                    state_n = ST_PAUSE;
                end else if (presc == PRESC_MAX) begin
                    presc_n = '0;
                    if (turn == SIDE_BLACK) begin
                        br_n = round_dec;
                        bt_n = total_dec;
                    end else begin
                        rr_n = round_dec;
                        rt_n = total_dec;
                    end
                    if (round_zero || total_zero) begin
                        timeout_n[turn] = 1'b1;
                        state_n         = ST_OVER;
                    end
                end else begin
                    presc_n = presc + PW'(1);
                end
            end
`ifdef CHESS_TIMER_PAUSE_EN
            ST_PAUSE: begin
                if (bus.game_over) begin
                    state_n = ST_OVER;
                end else if (pause_req) begin
                    state_n = ST_RUN;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus.rr_timer = rr;
    assign bus.rt_timer = rt;
    assign bus.br_timer = br;
    assign bus.bt_timer = bt;
    assign bus.turn     = turn;
    assign bus.timeout  = timeout;
    assign bus.running  = (state == ST_RUN);

endmodule

// File: tb/tb_chess_timer.sv
// Directed bench for chess_timer: two instances with different limits.
module tb_chess_timer;

    logic vga_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    always #5 vga_clk = ~vga_clk;

    chess_timer_if ifa ();
    chess_timer_if ifb ();

    chess_timer #(.CLK_HZ(4), .ROUND_LIMIT(16'h0010), .TOTAL_LIMIT(16'h0100)) dut_a (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (ifa)
    );

    chess_timer #(.CLK_HZ(4), .ROUND_LIMIT(16'h0100), .TOTAL_LIMIT(16'h0002)) dut_b (
        .vga_clk (vga_clk),
        .rst_n   (rst_n),
        .bus     (ifb)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance n clock edges, land 1 time unit after the last edge
    task automatic step(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic pulse_a_start();
        ifa.start = 1'b1; step(1); ifa.start = 1'b0;
    endtask

    task automatic pulse_a_move();
        ifa.move_done = 1'b1; step(1); ifa.move_done = 1'b0;
    endtask

    task automatic pulse_b_start();
        ifb.start = 1'b1; step(1); ifb.start = 1'b0;
    endtask

    initial begin
        ifa.start = 0; ifa.move_done = 0; ifa.game_over = 0;
        ifb.start = 0; ifb.move_done = 0; ifb.game_over = 0;
`ifdef CHESS_TIMER_PAUSE_EN
        ifa.pause = 0; ifb.pause = 0;
`endif
        #12;
        // reset contents
        chk("rst_rr", ifa.rr_timer, 16'h0010);
        chk("rst_rt", ifa.rt_timer, 16'h0100);
        chk("rst_br", ifa.br_timer, 16'h0010);
        chk("rst_bt", ifa.bt_timer, 16'h0100);
        chk("rst_turn", ifa.turn, 0);
        chk("rst_to", ifa.timeout, 0);
        chk("rst_run", ifa.running, 0);
        rst_n = 1'b1;
        step(2);

        // move_done in IDLE is ignored
        pulse_a_move();
        chk("idle_move_turn", ifa.turn, 0);
        chk("idle_move_run", ifa.running, 0);

        // basic count
        pulse_a_start();
        chk("start_run", ifa.running, 1);
        step(3);
        chk("pre_tick_rr", ifa.rr_timer, 16'h0010);
        step(1);
        chk("tick1_rr", ifa.rr_timer, 16'h0009);
        chk("tick1_rt", ifa.rt_timer, 16'h0059);
        chk("tick1_br", ifa.br_timer, 16'h0010);
        chk("tick1_bt", ifa.bt_timer, 16'h0100);

        // round flag-fall after 10 ticks
        step(35);
        chk("ff_pre_rr", ifa.rr_timer, 16'h0001);
        chk("ff_pre_to", ifa.timeout, 0);
        step(1);
        chk("ff_rr", ifa.rr_timer, 16'h0000);
        chk("ff_rt", ifa.rt_timer, 16'h0050);
        chk("ff_to", ifa.timeout, 2'b01);
        chk("ff_run", ifa.running, 0);
        step(20);
        chk("ff_hold_rr", ifa.rr_timer, 16'h0000);
        chk("ff_hold_rt", ifa.rt_timer, 16'h0050);
        chk("ff_hold_to", ifa.timeout, 2'b01);

        // restart from OVER, then move handoff after 3 ticks
        pulse_a_start();
        chk("rs_to", ifa.timeout, 0);
        chk("rs_rr", ifa.rr_timer, 16'h0010);
        chk("rs_rt", ifa.rt_timer, 16'h0100);
        chk("rs_run", ifa.running, 1);
        step(12);
        chk("t3_rr", ifa.rr_timer, 16'h0007);
        chk("t3_rt", ifa.rt_timer, 16'h0057);
        pulse_a_move();
        chk("mv_turn", ifa.turn, 1);
        chk("mv_rr", ifa.rr_timer, 16'h0010);
        chk("mv_rt", ifa.rt_timer, 16'h0057);
        step(3);
        chk("mv_pre_br", ifa.br_timer, 16'h0010);
        step(1);
        chk("mv_br", ifa.br_timer, 16'h0009);
        chk("mv_bt", ifa.bt_timer, 16'h0059);
        chk("mv_rt_kept", ifa.rt_timer, 16'h0057);

        // collision: move_done on the tick cycle
        step(3);
        pulse_a_move();
        chk("col_turn", ifa.turn, 0);
        chk("col_br", ifa.br_timer, 16'h0010);
        chk("col_bt", ifa.bt_timer, 16'h0059);
        step(3);
        chk("col_phase_rr", ifa.rr_timer, 16'h0010);
        step(1);
        chk("col_tick_rr", ifa.rr_timer, 16'h0009);
        chk("col_tick_rt", ifa.rt_timer, 16'h0056);

        // game_over freezes, start in RUN ignored beforehand
        pulse_a_start();
        chk("run_start_ign_rr", ifa.rr_timer, 16'h0009);
        ifa.game_over = 1'b1;
        step(1);
        chk("go_run", ifa.running, 0);
        step(10);
        chk("go_rr", ifa.rr_timer, 16'h0009);
        chk("go_rt", ifa.rt_timer, 16'h0056);
        chk("go_turn", ifa.turn, 0);
        ifa.game_over = 1'b0;

        // async reset mid-RUN
        pulse_a_start();
        step(4);
        chk("pre_rst_rr", ifa.rr_timer, 16'h0009);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rr", ifa.rr_timer, 16'h0010);
        chk("arst_rt", ifa.rt_timer, 16'h0100);
        chk("arst_run", ifa.running, 0);
        chk("arst_turn", ifa.turn, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // total flag-fall on instance B, then restart
        pulse_b_start();
        step(4);
        chk("b_t1_rt", ifb.rt_timer, 16'h0001);
        chk("b_t1_rr", ifb.rr_timer, 16'h0059);
        step(4);
        chk("b_ff_rt", ifb.rt_timer, 16'h0000);
        chk("b_ff_rr", ifb.rr_timer, 16'h0058);
        chk("b_ff_to", ifb.timeout, 2'b01);
        chk("b_ff_run", ifb.running, 0);
        pulse_b_start();
        chk("b_rs_rr", ifb.rr_timer, 16'h0100);
        chk("b_rs_rt", ifb.rt_timer, 16'h0002);
        chk("b_rs_to", ifb.timeout, 0);
        chk("b_rs_turn", ifb.turn, 0);
        chk("b_rs_run", ifb.running, 1);

`ifdef CHESS_TIMER_PAUSE_EN
        // pause/resume keeps prescaler phase
        pulse_a_start();
        step(2);
        ifa.pause = 1'b1; step(1); ifa.pause = 1'b0;
        chk("ps_run", ifa.running, 0);
        step(10);
        chk("ps_rr", ifa.rr_timer, 16'h0010);
        ifa.pause = 1'b1; step(1); ifa.pause = 1'b0;
        chk("ps_res_run", ifa.running, 1);
        step(1);
        chk("ps_res_rr", ifa.rr_timer, 16'h0010);
        step(1);
        chk("ps_tick_rr", ifa.rr_timer, 16'h0009);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/chess_timer.md
# chess_timer

Per-side game clock for the chess display path. Generates the four BCD `mm:ss` timer words (`rr_timer`, `rt_timer`, `br_timer`, `bt_timer`) that the display engine renders. Each side has a per-move round timer and a whole-game total timer; both count down only while that side is to move. Sits between game control (start / move-done / game-over events) and the display engine, in the `vga_clk` domain.

## Interface
- `CLK_HZ`, 25_000_000: `vga_clk` frequency; the one-second prescaler wraps at `CLK_HZ-1`.
- `ROUND_LIMIT`, 16'h0100: round-timer reload value, BCD `mm:ss` (01:00).
- `TOTAL_LIMIT`, 16'h1000: total-timer reload value, BCD `mm:ss` (10:00).

Ports:
- `vga_clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; begins a game.
- `move_done` in 1: one-cycle pulse; the side to move has completed its move.
- `game_over` in 1: level; a game result has been decided elsewhere.
- `pause` in 1: pause toggle pulse. Present only with `CHESS_TIMER_PAUSE_EN`.
- `rr_timer` out 16: red round timer, BCD `mm:ss`.
- `rt_timer` out 16: red total timer, BCD `mm:ss`.
- `br_timer` out 16: black round timer, BCD `mm:ss`.
- `bt_timer` out 16: black total timer, BCD `mm:ss`.
- `turn` out 1: side to move; 0 = red, 1 = black.
- `timeout` out 2: `{black, red}` flag set on flag-fall.
- `running` out 1: high in RUN.

## Operation
- **BCD format:** `[15:12]` minute tens, `[11:8]` minute ones, `[7:4]` second tens (0–5), `[3:0]` second ones.
  - Maximum value is 99:59.
  - Decrement borrows across digits: `ss` 00 wraps to 59 and the minutes decrement (e.g. 10:00 → 09:59).
  - A timer at 00:00 never decrements.
  - Limits must be valid BCD and nonzero; any other value is unsupported.
- **States:** IDLE, RUN, OVER, plus PAUSE when configured.
- **IDLE:**
  - All four timers hold their limits, `turn`=0, prescaler=0.
  - `start` → RUN.
- **RUN:**
  - The prescaler increments every cycle. At `CLK_HZ-1` it wraps to 0 and raises an internal tick.
  - On a tick, the active side's round and total timers both decrement by one second.
  - If either of those timers becomes 00:00, the side's `timeout` bit is set → OVER.
- **`move_done` in RUN:**
  - `turn` flips.
  - Both round timers reload to `ROUND_LIMIT`.
  - Prescaler clears to 0.
  - Total timers are kept.
- **Simultaneous `move_done` and tick:** `move_done` wins and the tick is discarded, so no decrement happens that cycle.
- **`game_over` in RUN:** → OVER. It takes priority over tick and `move_done` in the same cycle; timers freeze.
- **OVER:**
  - All timers, `turn` and `timeout` are frozen.
  - `start` reloads all timers, clears `timeout`, sets `turn`=0 and prescaler=0 → RUN.
- `start` in RUN is ignored. `move_done` outside RUN is ignored.
- Reset at any time returns to the IDLE contents.

## Timing
- **Reset values:**
  - `rr_timer`/`br_timer` = `ROUND_LIMIT`; `rt_timer`/`bt_timer` = `TOTAL_LIMIT`.
  - `turn`=0, `timeout`=2'b00, `running`=0.
  - State IDLE, prescaler 0.
- All outputs are registered; a decision made on cycle N is visible on cycle N+1.
- **After `start` (cycle S):**
  - `running`=1 from S+1.
  - The first tick is at prescaler value `CLK_HZ-1`, i.e. on the `CLK_HZ`-th RUN cycle.
  - The first decrement is visible one cycle after that tick.
- **`move_done` at cycle M:** the new `turn` and reloaded round timers are visible at M+1. The incoming side's first tick is `CLK_HZ` cycles after M+1.
- **Flag-fall:** the timer shows 00:00 on the same cycle that `timeout` and the OVER state become visible.

## Configuration
- **`CHESS_TIMER_PAUSE_EN` defined:**
  - The `pause` port exists.
  - `pause` in RUN → PAUSE: prescaler and timers hold, `running`=0.
  - `pause` in PAUSE → RUN, resuming from the held prescaler value.
  - `move_done` is ignored in PAUSE.
  - `game_over` in PAUSE → OVER; `start` in PAUSE is ignored.
- **Not defined:** no `pause` port and no PAUSE state; the prescaler never holds in RUN.

## Structure
- **Package `chess_timer_pkg`:**
  - State encoding.
  - Side constants `SIDE_RED`=0, `SIDE_BLACK`=1.
  - `BCD_ZERO`=16'h0000.
  - The BCD `mm:ss` width of 16.
- **Sub-module `bcd_mmss_dec`:** combinational, with input 16-bit value, outputs decremented value and `is_zero` (of the result). Instantiated twice, once for the active round timer and once for the active total timer.

## Test plan
- **Basic count:** `CLK_HZ`=4, `ROUND_LIMIT`=16'h0010, `TOTAL_LIMIT`=16'h0100. Reset, `start` → 4 cycles later `rr_timer`=16'h0009, `rt_timer`=16'h0059; `br_timer`=16'h0010 and `bt_timer`=16'h0100 unchanged.
- **Round flag-fall:** same setup, no `move_done` for 10 ticks → `rr_timer`=16'h0000, `rt_timer`=16'h0050, `timeout`=2'b01, `running`=0; 20 more cycles produce no change.
- **Move handoff:** `move_done` after 3 ticks → `turn`=1, `rr_timer`=16'h0010, `rt_timer`=16'h0057. The next tick gives `br_timer`=16'h0009, `bt_timer`=16'h0059.
- **Collision:** `move_done` asserted on the tick cycle → no decrement that cycle, `turn` flips, prescaler restarts at 0.
- **Total flag-fall and restart:**
  - Setup: `TOTAL_LIMIT`=16'h0002, `ROUND_LIMIT`=16'h0100.
  - After 2 ticks, `rt_timer`=0 and `timeout`=2'b01.
  - Then `start` → all timers reload, `timeout`=0, `turn`=0, RUN.
- **Freeze and reset:** `game_over` mid-RUN → timers freeze. `rst_n` low asynchronously mid-RUN → outputs return to the reset values immediately. With `CHESS_TIMER_PAUSE_EN`, pause and resume preserve the prescaler phase.
